// File: rtl/lcd_frame_reader_pkg.sv
// -----------------------------------------------------------------------------
// lcd_frame_reader_pkg
// Shared definitions for the LCD-side frame reader:
//   - ADDR_W       : byte address width of the 32 KB image buffer read port
//   - state_t      : reader FSM encoding (IDLE / FETCH / DRAIN)
//   - bar_colour() : RGB565 colour of each of the 8 test-pattern bars
// -----------------------------------------------------------------------------
package lcd_frame_reader_pkg;

  localparam int ADDR_W = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_frame_reader_pix_fifo.sv
// -----------------------------------------------------------------------------
// pix_fifo
// 4-entry x 18-bit first-word-fall-through FIFO holding {pixel, sof, eol}.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : push wr_data (the caller guarantees there is room)
//   wr_data   : {pix[15:0], sof, eol}
//   rd_en     : pop the head entry (the caller guarantees it is non-empty)
//   rd_data   : head entry, valid whenever count != 0
//   count     : current occupancy 0..4
// -----------------------------------------------------------------------------
module pix_fifo (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [17:0] wr_data,
  input  logic        rd_en,
  output logic [17:0] rd_data,
  output logic [2:0]  count
);

  logic [17:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: the storage is reset too, so the head word (and hence pix_data,
      // pix_sof, pix_eol) reads as zero out of reset; only 4 words, so cheap.
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, wr_en} - {2'b00, rd_en};
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/lcd_frame_reader.sv
// -----------------------------------------------------------------------------
// lcd_frame_reader
// Streams one stored frame out of the image buffer as RGB565 pixels.
// Pixel n lives at BASE_ADDR+2n (high byte) and BASE_ADDR+2n+1 (low byte).
// Optional feature macro: LCD_READER_TESTPAT_EN adds input test_mode, which
// (sampled at frame_start) replaces pixel data by 8 vertical colour bars.
// Ports:
//   clk, rst          : sole clock, synchronous active-high reset
//   frame_start       : one-cycle request to stream a frame (ignored if busy)
//   bram_addr/data    : buffer read port, data valid the cycle after address
//   pix_data/valid/ready, pix_sof, pix_eol : pixel stream to LCD controller
//   busy              : frame in progress
//   frame_done        : pulse after the final pixel is accepted
// -----------------------------------------------------------------------------
module lcd_frame_reader
  import lcd_frame_reader_pkg::*;
#(
  parameter int                IMG_W     = 160,
  parameter int                IMG_H     = 100,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
`ifdef LCD_READER_TESTPAT_EN
  input  logic              test_mode,
`endif
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [7:0]        bram_data,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
  output logic              frame_done
);

  localparam int          XW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int          YW        = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [15:0] LAST_BYTE = 16'(IMG_W * IMG_H * 2 - 1);

  state_t          state;
  logic [15:0]     rd_cnt;     // index of the byte currently on bram_addr
  logic            rd_vld;     // bram_data carries a requested byte this cycle
  logic            have_hi;    // pairing register holds a high byte
  logic [7:0]      hi_q;
  logic [2:0]      inflight;   // pixels with a byte in flight or awaiting pair
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;

  logic [2:0]      fifo_count;
  logic [17:0]     fifo_rd;
  logic [15:0]     pix_word;
  logic            issue, hi_issue, pair_wr, pix_fire, last_accept;

  // Credit covers both FIFO entries and pixels still being assembled, so a
  // pixel is only started if it is guaranteed a FIFO slot on arrival.
  assign issue       = (state == ST_FETCH) &&
                       (({1'b0, fifo_count} + {1'b0, inflight}) < 4'd4);
  assign hi_issue    = issue && !rd_cnt[0];
  assign pair_wr     = rd_vld && have_hi;
  assign pix_fire    = pix_valid && pix_ready;
  // In DRAIN nothing else is outstanding once the FIFO holds one pixel and
  // inflight is zero, so that pixel is the last of the frame.
  assign last_accept = (state == ST_DRAIN) && pix_fire &&
                       (fifo_count == 3'd1) && (inflight == 3'd0);

`ifdef LCD_READER_TESTPAT_EN
  localparam int BAR_W = (IMG_W >= 8) ? IMG_W / 8 : 1;
  logic       test_mode_q;
  logic [2:0] bar_idx;

  always_comb begin
    bar_idx = 3'd7;
    if ((int'(x) / BAR_W) < 8) bar_idx = 3'(int'(x) / BAR_W);
    pix_word = test_mode_q ? bar_colour(bar_idx) : {hi_q, bram_data};
  end
`else
  assign pix_word = {hi_q, bram_data};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bram_addr  <= BASE_ADDR;
      rd_cnt     <= '0;
      rd_vld     <= 1'b0;
      have_hi    <= 1'b0;
      hi_q       <= '0;
      inflight   <= '0;
      x          <= '0;
      y          <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef LCD_READER_TESTPAT_EN
      test_mode_q <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      rd_vld     <= issue;
      inflight   <= inflight + {2'b00, hi_issue} - {2'b00, pair_wr};

      // Pairing stage: first returned byte is high, second completes a pixel.
      if (rd_vld) begin
        if (!have_hi) begin
          hi_q    <= bram_data;
          have_hi <= 1'b1;
        end else begin
          have_hi <= 1'b0;
          if (x == XW'(IMG_W - 1)) begin
            x <= '0;
            y <= (y == YW'(IMG_H - 1)) ? '0 : y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          // frame_done high means the previous frame ended this very edge.
          if (frame_start && !frame_done) begin
            state     <= ST_FETCH;
            busy      <= 1'b1;
            rd_cnt    <= '0;
            bram_addr <= BASE_ADDR;
            x         <= '0;
            y         <= '0;
            have_hi   <= 1'b0;
            inflight  <= '0;
`ifdef LCD_READER_TESTPAT_EN
            test_mode_q <= test_mode;
`endif
          end
        end
        ST_FETCH: begin
          if (issue) begin
            if (rd_cnt == LAST_BYTE) begin
              state <= ST_DRAIN;
            end else begin
              rd_cnt    <= rd_cnt + 16'd1;
              bram_addr <= bram_addr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (last_accept) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            bram_addr  <= BASE_ADDR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pix_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pair_wr),
    .wr_data ({pix_word, (x == '0) && (y == '0), x == XW'(IMG_W - 1)}),
    .rd_en   (pix_fire),
    .rd_data (fifo_rd),
    .count   (fifo_count)
  );

  assign pix_valid = (fifo_count != 3'd0);
  assign pix_data  = fifo_rd[17:2];
  assign pix_sof   = fifo_rd[1];
  assign pix_eol   = fifo_rd[0];

endmodule
